// File: rtl/mux4_1_seq_ctrl_if.sv
// rtl/mux4_1_seq_ctrl_if.sv - upstream/downstream handshake bundle of the mux4_1 lane sequencer
interface mux4_1_seq_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] select;
  logic       out_valid;
  logic       out_ready;
  logic       last;
  logic       data_valid;

  modport master (
    input  in_valid, out_ready,
    output in_ready, select, out_valid, last, data_valid
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, select, out_valid, last, data_valid
  );
endinterface

// File: rtl/mux4_1_seq_ctrl.sv
// rtl/mux4_1_seq_ctrl.sv - drives mux4_1 select to serialize masked lanes of each bundle for N rounds
module mux4_1_seq_ctrl #(
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ROUND_W-1:0] num_rounds,
  input  logic [3:0]         lane_mask,
  mux4_1_seq_ctrl_if.master  bus,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, WAIT_IN, EMIT, DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         select_q, select_d;
  logic [ROUND_W-1:0] round_cnt_q, round_cnt_d;
  logic [ROUND_W-1:0] num_q, num_d;
  logic [3:0]         mask_q, mask_d;
  logic               data_valid_q, data_valid_d;

  logic [1:0]         low_sel;
  logic [1:0]         next_sel;
  logic               higher;
  logic               final_round;

  // Lowest set lane, and the nearest set lane strictly above the current select.
  always_comb begin
    low_sel  = 2'd0;
    next_sel = select_q;
    higher   = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i]) low_sel = 2'(i);
    end
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(select_q))) begin
        next_sel = 2'(i);
        higher   = 1'b1;
      end
    end
  end

  assign final_round = (round_cnt_q == (num_q - ROUND_W'(1)));

  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    round_cnt_d  = round_cnt_q;
    num_d        = num_q;
    mask_d       = mask_q;
    data_valid_d = (state_q == EMIT) && bus.out_ready;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((num_rounds != '0) && (lane_mask != 4'd0)) begin
            num_d       = num_rounds;
            mask_d      = lane_mask;
            round_cnt_d = '0;
            state_d     = WAIT_IN;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT_IN: begin
        if (bus.in_valid) begin
          select_d = low_sel;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (higher) begin
            select_d = next_sel;
          end else if (final_round) begin
            state_d = DONE;
          end else begin
            // Compared before incrementing, so the counter never wraps.
            round_cnt_d = round_cnt_q + ROUND_W'(1);
            state_d     = WAIT_IN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      select_q     <= 2'd0;
      round_cnt_q  <= '0;
      num_q        <= '0;
      mask_q       <= 4'd0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      round_cnt_q  <= round_cnt_d;
      num_q        <= num_d;
      mask_q       <= mask_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Handshake outputs decode only registered state: no path from in_valid/out_ready.
  assign bus.in_ready   = (state_q == WAIT_IN);
  assign bus.out_valid  = (state_q == EMIT);
  assign bus.select     = select_q;
  assign bus.last       = (state_q == EMIT) && final_round && !higher;
  assign bus.data_valid = data_valid_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
endmodule

// File: tb/tb_mux4_1_seq_ctrl.sv
// tb/tb_mux4_1_seq_ctrl.sv - scoreboard bench for mux4_1_seq_ctrl with a registered mux4_1 model
module tb_mux4_1_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_rounds = 8'd0;
  logic [3:0] lane_mask = 4'd0;
  logic       busy;
  logic       done;

  mux4_1_seq_ctrl_if bus ();

  mux4_1_seq_ctrl #(.ROUND_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_rounds (num_rounds),
    .lane_mask  (lane_mask),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [15:0] lanes [4];
  logic [15:0] mux_q;
  always @(posedge clk) mux_q <= lanes[bus.select];

  logic [2:0]  exp_beat_q [$];
  logic [15:0] exp_data_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_beat_q.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected got sel=%0d last=%0d, none expected", bus.select, bus.last);
        end else begin
          logic [2:0] e;
          e = exp_beat_q.pop_front();
          if ({bus.last, bus.select} !== e)
            begin n_err++; $display("FAIL beat got last/sel=%0d/%0d want %0d/%0d", bus.last, bus.select, e[2], e[1:0]); end
        end
      end
      if (bus.data_valid) begin
        n_cmp++;
        if (exp_data_q.size() == 0) begin
          n_err++;
          $display("FAIL data_valid_unexpected got mux=%h, none expected", mux_q);
        end else begin
          logic [15:0] d;
          d = exp_data_q.pop_front();
          if (mux_q !== d) begin n_err++; $display("FAIL mux_out got %h want %h", mux_q, d); end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lane_word(int k, int i);
    return 16'(((4 - i) << 8) | k);
  endfunction

  // Stimulus only: runs one job, pushing expected beats as each bundle is offered.
  task automatic drive_job(input logic [3:0] mask, input logic [7:0] rounds, input int stall_beat,
                           input int stall_len, input int abort_beat, input bit poke,
                           output int n_inrdy, output int n_beats, output int first_acc,
                           output int last_acc, output int done_cyc, output int stall_bad,
                           output int stall_sel, output bit timed_out, output bit rdy_after_start);
    int k = 0;
    int cyc = 0;
    int stalled = 0;
    int top = 0;
    bit fin = 1'b0;
    n_inrdy = 0; n_beats = 0; first_acc = -1; last_acc = -1; done_cyc = -1;
    stall_bad = 0; stall_sel = -1; timed_out = 1'b0;
    for (int i = 0; i < 4; i++) if (mask[i]) top = i;
    start = 1'b1; num_rounds = rounds; lane_mask = mask;
    tick();
    start = 1'b0;
    rdy_after_start = bus.in_ready;
    while (!fin && cyc < 400) begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      start = 1'b0;
      if (bus.in_ready) begin
        n_inrdy++;
        if (k < int'(rounds)) begin
          for (int i = 0; i < 4; i++) begin
            lanes[i] = lane_word(k, i);
            if (mask[i]) begin
              exp_beat_q.push_back({(k == int'(rounds) - 1) && (i == top), 2'(i)});
              exp_data_q.push_back(lane_word(k, i));
            end
          end
          bus.in_valid = 1'b1;
          k++;
        end
      end
      if (bus.out_valid) begin
        if (abort_beat >= 0 && n_beats == abort_beat) begin
          rst_n = 1'b0;
          bus.in_valid = 1'b0;
          return;
        end
        if (n_beats == stall_beat && stalled < stall_len) begin
          bus.out_ready = 1'b0;
          if (stalled == 0) stall_sel = int'(bus.select);
          else if (int'(bus.select) != stall_sel) stall_bad++;
          stalled++;
        end else begin
          if (n_beats == 0) first_acc = cyc;
          last_acc = cyc;
          n_beats++;
          if (poke && n_beats == 2) begin
            start = 1'b1; num_rounds = 8'd5; lane_mask = 4'b0001;
          end
        end
      end
      if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    timed_out = !fin;
  endtask

  int  n_inrdy, n_beats, first_acc, last_acc, done_cyc, stall_bad, stall_sel;
  bit  timed_out, rdy1;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({bus.select, bus.out_valid, bus.in_ready, bus.last, bus.data_valid, busy, done} !== 8'd0)
      begin n_err++; $display("FAIL reset_outputs got %b want 0", {bus.select, bus.out_valid, bus.in_ready, bus.last, bus.data_valid, busy, done}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_mask();
    drive_job(4'b1111, 8'd1, -1, 0, -1, 1'b0, n_inrdy, n_beats, first_acc, last_acc, done_cyc, stall_bad, stall_sel, timed_out, rdy1);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL full_timeout got %0d want 0", timed_out); end
    n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL full_start_to_ready got %0d want 1", rdy1); end
    n_cmp++; if (n_beats != 4) begin n_err++; $display("FAIL full_beats got %0d want 4", n_beats); end
    n_cmp++; if (last_acc - first_acc != 3) begin n_err++; $display("FAIL full_consecutive got span %0d want 3", last_acc - first_acc); end
    n_cmp++; if (done_cyc - last_acc != 1) begin n_err++; $display("FAIL full_done_latency got %0d want 1", done_cyc - last_acc); end
    n_cmp++; if (n_inrdy != 1) begin n_err++; $display("FAIL full_in_ready got %0d want 1", n_inrdy); end
    n_cmp++; if (exp_beat_q.size() + exp_data_q.size() != 0) begin n_err++; $display("FAIL full_drain got %0d left want 0", exp_beat_q.size() + exp_data_q.size()); end
    tick();
  endtask

  task automatic test_sparse_mask();
    drive_job(4'b1010, 8'd2, -1, 0, -1, 1'b0, n_inrdy, n_beats, first_acc, last_acc, done_cyc, stall_bad, stall_sel, timed_out, rdy1);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL sparse_timeout got %0d want 0", timed_out); end
    n_cmp++; if (n_beats != 4) begin n_err++; $display("FAIL sparse_beats got %0d want 4", n_beats); end
    n_cmp++; if (n_inrdy != 2) begin n_err++; $display("FAIL sparse_in_ready got %0d want 2", n_inrdy); end
    n_cmp++; if (done_cyc - last_acc != 1) begin n_err++; $display("FAIL sparse_done_latency got %0d want 1", done_cyc - last_acc); end
    n_cmp++; if (exp_beat_q.size() + exp_data_q.size() != 0) begin n_err++; $display("FAIL sparse_drain got %0d left want 0", exp_beat_q.size() + exp_data_q.size()); end
    tick();
  endtask

  task automatic test_backpressure();
    drive_job(4'b1111, 8'd1, 2, 3, -1, 1'b0, n_inrdy, n_beats, first_acc, last_acc, done_cyc, stall_bad, stall_sel, timed_out, rdy1);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL bp_timeout got %0d want 0", timed_out); end
    n_cmp++; if (stall_sel != 2) begin n_err++; $display("FAIL bp_stall_select got %0d want 2", stall_sel); end
    n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL bp_select_held got %0d changes want 0", stall_bad); end
    n_cmp++; if (last_acc - first_acc != 6) begin n_err++; $display("FAIL bp_span got %0d want 6", last_acc - first_acc); end
    n_cmp++; if (exp_beat_q.size() + exp_data_q.size() != 0) begin n_err++; $display("FAIL bp_drain got %0d left want 0", exp_beat_q.size() + exp_data_q.size()); end
    tick();
  endtask

  task automatic test_degenerate();
    for (int c = 0; c < 2; c++) begin
      start = 1'b1;
      num_rounds = (c == 0) ? 8'd0 : 8'd3;
      lane_mask  = (c == 0) ? 4'b1111 : 4'b0000;
      tick();
      start = 1'b0;
      n_cmp++;
      if ({done, busy, bus.in_ready, bus.out_valid} !== 4'b1100)
        begin n_err++; $display("FAIL degen%0d_pulse got %b want 1100", c, {done, busy, bus.in_ready, bus.out_valid}); end
      tick();
      n_cmp++;
      if ({done, busy, bus.in_ready, bus.out_valid} !== 4'b0000)
        begin n_err++; $display("FAIL degen%0d_after got %b want 0000", c, {done, busy, bus.in_ready, bus.out_valid}); end
    end
  endtask

  task automatic test_reset_mid_job();
    drive_job(4'b1111, 8'd3, -1, 0, 2, 1'b0, n_inrdy, n_beats, first_acc, last_acc, done_cyc, stall_bad, stall_sel, timed_out, rdy1);
    #1;
    n_cmp++;
    if ({bus.select, bus.out_valid, bus.in_ready, bus.last, bus.data_valid, busy, done} !== 8'd0)
      begin n_err++; $display("FAIL midreset_outputs got %b want 0", {bus.select, bus.out_valid, bus.in_ready, bus.last, bus.data_valid, busy, done}); end
    exp_beat_q.delete();
    exp_data_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL midreset_no_done got %b want 00", {done, busy}); end
    drive_job(4'b0110, 8'd2, -1, 0, -1, 1'b0, n_inrdy, n_beats, first_acc, last_acc, done_cyc, stall_bad, stall_sel, timed_out, rdy1);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL midreset_rerun_timeout got %0d want 0", timed_out); end
    n_cmp++; if (n_beats != 4) begin n_err++; $display("FAIL midreset_rerun_beats got %0d want 4", n_beats); end
    n_cmp++; if (exp_beat_q.size() + exp_data_q.size() != 0) begin n_err++; $display("FAIL midreset_drain got %0d left want 0", exp_beat_q.size() + exp_data_q.size()); end
    tick();
  endtask

  task automatic test_start_while_busy();
    drive_job(4'b1111, 8'd2, -1, 0, -1, 1'b1, n_inrdy, n_beats, first_acc, last_acc, done_cyc, stall_bad, stall_sel, timed_out, rdy1);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL busy_timeout got %0d want 0", timed_out); end
    n_cmp++; if (n_beats != 8) begin n_err++; $display("FAIL busy_beats got %0d want 8", n_beats); end
    n_cmp++; if (n_inrdy != 2) begin n_err++; $display("FAIL busy_in_ready got %0d want 2", n_inrdy); end
    n_cmp++; if (exp_beat_q.size() + exp_data_q.size() != 0) begin n_err++; $display("FAIL busy_drain got %0d left want 0", exp_beat_q.size() + exp_data_q.size()); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_idle_after got %0d want 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) lanes[i] = 16'h0;
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_backpressure();
    test_degenerate();
    test_reset_mid_job();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
